// File: rtl/fan_timer_countdown.sv
// Countdown timer for a fan: four selectable minute presets, mm:ss BCD display,
// start/pause/resume, cancel, and a one-cycle timeout strobe when 00:00 is reached.
module fan_timer_countdown #(
   parameter int PRESET0 = 1,
   parameter int PRESET1 = 3,
   parameter int PRESET2 = 5,
   parameter int PRESET3 = 10
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       clk_sec,
   input  logic       set_pulse,
   input  logic       start_pulse,
   input  logic       cancel_pulse,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [1:0] preset_idx,
   output logic       running,
   output logic       timeout,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic       running_q, running_d;
   logic       timeout_q, timeout_d;

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [7:0] preset_bcd(input logic [1:0] i);
      logic [7:0] r;
      case (i)
         2'd0:    r = to_bcd(PRESET0);
         2'd1:    r = to_bcd(PRESET1);
         2'd2:    r = to_bcd(PRESET2);
         default: r = to_bcd(PRESET3);
      endcase
      return r;
   endfunction

   // One-second BCD decrement of {min, sec}; 00 seconds borrows to 59.
   function automatic logic [15:0] dec_mmss(input logic [15:0] v);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = v;
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else if (st != 4'd0) begin
         st = st - 4'd1;
         so = 4'd9;
      end else begin
         st = 4'd5;
         so = 4'd9;
         if (mo != 4'd0) begin
            mo = mo - 4'd1;
         end else begin
            mt = mt - 4'd1;
            mo = 4'd9;
         end
      end
      return {mt, mo, st, so};
   endfunction

   // Priority cancel > start > set > clk_sec; an input that is ignored in the
   // current state does not block a lower-priority one.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      min_d     = min_q;
      sec_d     = sec_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_pulse) begin
               state_d = S_RUN;
            end else if (set_pulse) begin
               idx_d = idx_q + 2'd1;
               min_d = preset_bcd(idx_q + 2'd1);
               sec_d = 8'h00;
            end
         end
         S_RUN: begin
            if (cancel_pulse) begin
               state_d = S_IDLE;
               min_d   = preset_bcd(idx_q);
               sec_d   = 8'h00;
            end else if (start_pulse) begin
               state_d = S_PAUSE;
            end else if (clk_sec) begin
               {min_d, sec_d} = dec_mmss({min_q, sec_q});
               if ({min_q, sec_q} == 16'h0001) begin
                  state_d   = S_DONE;
                  timeout_d = 1'b1;
               end
            end
         end
         S_PAUSE: begin
            if (cancel_pulse) begin
               state_d = S_IDLE;
               min_d   = preset_bcd(idx_q);
               sec_d   = 8'h00;
            end else if (start_pulse) begin
               state_d = S_RUN;
            end
         end
         default: begin
            if (cancel_pulse || start_pulse || set_pulse) begin
               state_d = S_IDLE;
               min_d   = preset_bcd(idx_q);
               sec_d   = 8'h00;
            end
         end
      endcase
      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q   <= S_IDLE;
         idx_q     <= 2'd0;
         min_q     <= to_bcd(PRESET0);
         sec_q     <= 8'h00;
         running_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         running_q <= running_d;
         timeout_q <= timeout_d;
      end
   end

   assign min_bcd    = min_q;
   assign sec_bcd    = sec_q;
   assign preset_idx = idx_q;
   assign running    = running_q;
   assign timeout    = timeout_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_fan_timer_countdown.sv
// Bench for fan_timer_countdown: directed scenarios plus random pulses, checked
// against a model that tracks the remaining time as a plain count of seconds.
module tb_fan_timer_countdown;

   logic       clk = 1'b0;
   logic       reset_p;
   logic       clk_sec, set_pulse, start_pulse, cancel_pulse;
   logic [7:0] min_bcd, sec_bcd;
   logic [1:0] preset_idx;
   logic       running, timeout;
   logic [1:0] state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   fan_timer_countdown dut (
      .clk          (clk),
      .reset_p      (reset_p),
      .clk_sec      (clk_sec),
      .set_pulse    (set_pulse),
      .start_pulse  (start_pulse),
      .cancel_pulse (cancel_pulse),
      .min_bcd      (min_bcd),
      .sec_bcd      (sec_bcd),
      .preset_idx   (preset_idx),
      .running      (running),
      .timeout      (timeout),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   // Model: mode 0 idle, 1 counting, 2 paused, 3 finished.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int preset_min[4] = '{1, 3, 5, 10};
   int m_mode, m_idx, m_rem;
   bit m_tout;

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_idx  = 0;
      m_rem  = preset_min[0] * 60;
      m_tout = 1'b0;
   endtask

   task automatic model_step(input bit cl, input bit st, input bit se, input bit cs);
      m_tout = 1'b0;
      case (m_mode)
         M_IDLE: begin
            if (st) m_mode = M_RUN;
            else if (se) begin
               m_idx = (m_idx + 1) % 4;
               m_rem = preset_min[m_idx] * 60;
            end
         end
         M_RUN: begin
            if (cl) begin
               m_mode = M_IDLE;
               m_rem  = preset_min[m_idx] * 60;
            end else if (st) m_mode = M_PAUSE;
            else if (cs) begin
               m_rem = m_rem - 1;
               if (m_rem == 0) begin
                  m_mode = M_DONE;
                  m_tout = 1'b1;
               end
            end
         end
         M_PAUSE: begin
            if (cl) begin
               m_mode = M_IDLE;
               m_rem  = preset_min[m_idx] * 60;
            end else if (st) m_mode = M_RUN;
         end
         default: begin
            if (cl || st || se) begin
               m_mode = M_IDLE;
               m_rem  = preset_min[m_idx] * 60;
            end
         end
      endcase
   endtask

   task automatic check_model(input string tag);
      check_eq({tag, ".mmss"}, {min_bcd, sec_bcd}, {bcd(m_rem / 60), bcd(m_rem % 60)});
      check_eq({tag, ".idx"}, 32'(preset_idx), 32'(m_idx));
      check_eq({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
      check_eq({tag, ".timeout"}, 32'(timeout), 32'(m_tout));
   endtask

   // Called 1 time unit after a rising edge; applies one cycle of inputs.
   task automatic step(input bit cl, input bit st, input bit se, input bit cs);
      cancel_pulse = cl;
      start_pulse  = st;
      set_pulse    = se;
      clk_sec      = cs;
      @(posedge clk);
      model_step(cl, st, se, cs);
      #1;
      check_model("step");
      cancel_pulse = 1'b0;
      start_pulse  = 1'b0;
      set_pulse    = 1'b0;
      clk_sec      = 1'b0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1);
   endtask

   // Asserts reset between clock edges and checks outputs before the next edge.
   task automatic apply_reset();
      #2;
      reset_p = 1'b1;
      #1;
      model_reset();
      check_eq("rst.async.mmss", {min_bcd, sec_bcd}, 16'h0100);
      check_eq("rst.async.idx", 32'(preset_idx), 32'd0);
      check_eq("rst.async.run_tout", {running, timeout}, 2'b00);
      @(posedge clk);
      #1;
      check_model("rst.held");
      reset_p = 1'b0;
   endtask

   initial begin
      int tout_seen;
      reset_p      = 1'b1;
      clk_sec      = 1'b0;
      set_pulse    = 1'b0;
      start_pulse  = 1'b0;
      cancel_pulse = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_model("reset");
      reset_p = 1'b0;

      // Preset cycling.
      step(0, 0, 1, 0); check_eq("cyc.1", {min_bcd, 6'd0, preset_idx}, 16'h0301);
      step(0, 0, 1, 0); check_eq("cyc.2", {min_bcd, 6'd0, preset_idx}, 16'h0502);
      step(0, 0, 1, 0); check_eq("cyc.3", {min_bcd, 6'd0, preset_idx}, 16'h1003);
      step(0, 0, 1, 0); check_eq("cyc.4", {min_bcd, 6'd0, preset_idx}, 16'h0100);
      tick(3);
      check_eq("idle.no_count", {min_bcd, sec_bcd}, 16'h0100);

      // Borrow from 03:00.
      step(0, 0, 1, 0);
      step(0, 1, 0, 1);
      check_eq("start.no_dec", {min_bcd, sec_bcd}, 16'h0300);
      tick(1);
      check_eq("borrow.0259", {min_bcd, sec_bcd}, 16'h0259);
      tick(59);
      check_eq("borrow.0200", {min_bcd, sec_bcd}, 16'h0200);

      // Expiry from 01:00.
      apply_reset();
      step(0, 1, 0, 0);
      tout_seen = 0;
      for (int i = 0; i < 60; i++) begin
         step(0, 0, 0, 1);
         if (timeout) tout_seen++;
      end
      check_eq("expire.mmss", {min_bcd, sec_bcd}, 16'h0000);
      check_eq("expire.tout", 32'(timeout), 32'd1);
      check_eq("expire.tout_once", 32'(tout_seen), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 1);
         if (timeout) tout_seen++;
      end
      check_eq("expire.hold", {min_bcd, sec_bcd, 7'd0, running}, 24'h000000);
      check_eq("expire.no_retrigger", 32'(tout_seen), 32'd1);
      step(0, 0, 1, 0);
      check_eq("done.reload", {min_bcd, sec_bcd, 6'd0, preset_idx}, 24'h010000);

      // Pause at 00:45.
      step(0, 1, 0, 0);
      tick(15);
      step(0, 1, 0, 1);
      check_eq("pause.hold", {min_bcd, sec_bcd, 7'd0, running}, 24'h004500);
      tick(5);
      check_eq("pause.ignore_sec", {min_bcd, sec_bcd}, 16'h0045);
      step(0, 0, 1, 0);
      check_eq("pause.ignore_set", 32'(preset_idx), 32'd0);
      step(0, 1, 0, 0);
      tick(1);
      check_eq("resume.0044", {min_bcd, sec_bcd}, 16'h0044);

      // Cancel beats start at 04:12 on index 2.
      apply_reset();
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      tick(48);
      check_eq("cancel.pre", {min_bcd, sec_bcd}, 16'h0412);
      step(1, 1, 0, 0);
      check_eq("cancel.idle", {min_bcd, sec_bcd, 7'd0, running}, 24'h050000);

      // Reset mid-count at 02:30.
      apply_reset();
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      tick(30);
      check_eq("midrst.pre", {min_bcd, sec_bcd}, 16'h0230);
      apply_reset();

      // Random pulses.
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(63) == 0, $urandom_range(31) == 0,
              $urandom_range(15) == 0, $urandom_range(1) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
